// File: rtl/sort_pkg.sv
// Shared definitions for the sort engine: controller state encoding and default sizing.
package sort_pkg;

   localparam int unsigned DefaultN = 8;
   localparam int unsigned DefaultW = 4;

   typedef enum logic [1:0] {
      StLoad  = 2'd0,
      StSort  = 2'd1,
      StDrain = 2'd2
   } sort_state_e;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned W-bit magnitude comparator with one-hot greater/less/equal outputs.
module mag_cmp
   import sort_pkg::*;
#(
   parameter int unsigned W = DefaultW
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         g,
   output logic         l,
   output logic         e
);

   always_comb begin
      g = 1'b0;
      l = 1'b0;
      e = 1'b0;
      if (a == b) begin
         e = 1'b1;
      end else if (a > b) begin
         g = 1'b1;
      end else begin
         l = 1'b1;
      end
   end

endmodule

// File: rtl/sort_engine.sv
// Batch bubble sorter: loads N entries, sorts in place one compare per cycle, then streams
// them out in ascending order.
module sort_engine
   import sort_pkg::*;
#(
   parameter int unsigned N = DefaultN,
   parameter int unsigned W = DefaultW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy
);

   localparam int unsigned     IdxW     = $clog2(N);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(N - 1);
   localparam logic [IdxW-1:0] LastPass = IdxW'(N - 2);

   sort_state_e     state_q, state_d;
   logic [IdxW-1:0] wr_idx_q, wr_idx_d;
   logic [IdxW-1:0] rd_idx_q, rd_idx_d;
   logic [IdxW-1:0] j_q, j_d;
   logic [IdxW-1:0] pass_q, pass_d;
   logic            swap_flag_q, swap_flag_d;
   logic [W-1:0]    mem_q [N];
   logic [W-1:0]    mem_d [N];

   logic [IdxW-1:0] j_nxt;
   logic [W-1:0]    cmp_a, cmp_b;
   logic            cmp_g, cmp_l, cmp_e;
   logic            do_swap;
   logic            pass_end;

   assign j_nxt = j_q + IdxW'(1);
   assign cmp_a = mem_q[j_q];
   assign cmp_b = mem_q[j_nxt];

   mag_cmp #(
      .W(W)
   ) u_cmp (
      .a(cmp_a),
      .b(cmp_b),
      .g(cmp_g),
      .l(cmp_l),
      .e(cmp_e)
   );

   // Only a strict greater-than swaps, which keeps equal entries in load order.
   assign do_swap  = cmp_g & ~(cmp_l | cmp_e);
   assign pass_end = (j_q == (LastPass - pass_q));

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      j_d         = j_q;
      pass_d      = pass_q;
      swap_flag_d = swap_flag_q;
      mem_d       = mem_q;

      unique case (state_q)
         StLoad: begin
            if (in_valid) begin
               mem_d[wr_idx_q] = in_data;
               if (wr_idx_q == LastIdx) begin
                  wr_idx_d    = '0;
                  j_d         = '0;
                  pass_d      = '0;
                  swap_flag_d = 1'b0;
                  state_d     = StSort;
               end else begin
                  wr_idx_d = wr_idx_q + IdxW'(1);
               end
            end
         end
         StSort: begin
            if (do_swap) begin
               mem_d[j_q]   = cmp_b;
               mem_d[j_nxt] = cmp_a;
            end
            if (pass_end) begin
               j_d         = '0;
               swap_flag_d = 1'b0;
               // A clean pass means the batch is already ordered.
               if (!(swap_flag_q | do_swap) || (pass_q == LastPass)) begin
                  pass_d  = '0;
                  state_d = StDrain;
               end else begin
                  pass_d = pass_q + IdxW'(1);
               end
            end else begin
               j_d         = j_nxt;
               swap_flag_d = swap_flag_q | do_swap;
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (rd_idx_q == LastIdx) begin
                  rd_idx_d = '0;
                  wr_idx_d = '0;
                  state_d  = StLoad;
               end else begin
                  rd_idx_d = rd_idx_q + IdxW'(1);
               end
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StLoad;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         j_q         <= '0;
         pass_q      <= '0;
         swap_flag_q <= 1'b0;
         for (int i = 0; i < int'(N); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         j_q         <= j_d;
         pass_q      <= pass_d;
         swap_flag_q <= swap_flag_d;
         mem_q       <= mem_d;
      end
   end

   assign in_ready  = (state_q == StLoad) & ~rst;
   assign out_valid = (state_q == StDrain);
   assign out_data  = out_valid ? mem_q[rd_idx_q] : '0;
   assign out_last  = out_valid & (rd_idx_q == LastIdx);
   assign busy      = (state_q == StSort);

endmodule

// File: tb/tb_sort_engine.sv
// Directed self-checking bench for sort_engine with N=8, W=4.
module tb_sort_engine;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;
   logic       out_last;
   logic       busy;

   int n_cmp;
   int n_err;

   sort_engine #(
      .N(8),
      .W(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .out_last (out_last),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entry i of a batch lives in nibble i (entry 0 in the low nibble).
   task automatic load_beats(input logic [31:0] v, input int count);
      for (int i = 0; i < count; i++) begin
         in_valid = 1'b1;
         in_data  = v[i*4 +: 4];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 4'h0;
   endtask

   task automatic run_sort(output int cycles);
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   task automatic drain_collect(output logic [31:0] d, output logic [7:0] lm, output int beats);
      int cyc;
      d         = '0;
      lm        = '0;
      beats     = 0;
      cyc       = 0;
      out_ready = 1'b1;
      while (beats < 8 && cyc < 50) begin
         if (out_valid) begin
            d[beats*4 +: 4] = out_data;
            lm[beats]       = out_last;
            beats++;
         end
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      #3;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_ready_during: got %b want 0", in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, out_last, busy, out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b last=%b busy=%b data=%h want 1 0 0 0 0",
                  in_ready, out_valid, out_last, busy, out_data);
      end
   endtask

   task automatic test_mixed();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h813F0937, 8);
      n_cmp++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL mixed_sort_flags: got busy/rdy/ov=%b want 100", {busy, in_ready, out_valid});
      end
      run_sort(cyc);
      n_cmp++;
      if (cyc < 7 || cyc > 28) begin
         n_err++;
         $display("FAIL mixed_busy_len: got %0d want 7..28", cyc);
      end
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'hF9873310 || beats !== 8) begin
         n_err++;
         $display("FAIL mixed_data: got %h (%0d beats) want f9873310 (8)", d, beats);
      end
      n_cmp++;
      if (lm !== 8'h80) begin
         n_err++;
         $display("FAIL mixed_last: got %b want 10000000", lm);
      end
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL mixed_back_to_load: got rdy/ov=%b want 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_sorted();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h76543210, 8);
      run_sort(cyc);
      n_cmp++;
      if (cyc !== 7) begin
         n_err++;
         $display("FAIL sorted_busy_len: got %0d want 7", cyc);
      end
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'h76543210 || lm !== 8'h80) begin
         n_err++;
         $display("FAIL sorted_data: got %h last %b want 76543210 last 10000000", d, lm);
      end
   endtask

   task automatic test_descending();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h89ABCDEF, 8);
      run_sort(cyc);
      n_cmp++;
      if (cyc !== 28) begin
         n_err++;
         $display("FAIL desc_busy_len: got %0d want 28", cyc);
      end
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'hFEDCBA98 || lm !== 8'h80) begin
         n_err++;
         $display("FAIL desc_data: got %h last %b want fedcba98 last 10000000", d, lm);
      end
   endtask

   task automatic test_equal();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h55555555, 8);
      run_sort(cyc);
      n_cmp++;
      if (cyc !== 7) begin
         n_err++;
         $display("FAIL equal_busy_len: got %0d want 7", cyc);
      end
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'h55555555 || beats !== 8) begin
         n_err++;
         $display("FAIL equal_data: got %h (%0d beats) want 55555555 (8)", d, beats);
      end
   endtask

   task automatic test_stall();
      logic [31:0] d;
      logic [7:0]  lm;
      logic [3:0]  prev_d;
      logic        prev_l;
      logic        have_prev;
      int          beats, cyc, scyc;
      load_beats(32'h813F0937, 8);
      run_sort(scyc);
      d         = '0;
      lm        = '0;
      beats     = 0;
      cyc       = 0;
      have_prev = 1'b0;
      prev_d    = 4'h0;
      prev_l    = 1'b0;
      while (beats < 8 && cyc < 60) begin
         out_ready = (cyc % 2 == 1);
         if (have_prev) begin
            n_cmp++;
            if (out_data !== prev_d || out_last !== prev_l) begin
               n_err++;
               $display("FAIL stall_hold: got data=%h last=%b want data=%h last=%b",
                        out_data, out_last, prev_d, prev_l);
            end
         end
         if (out_valid && out_ready) begin
            d[beats*4 +: 4] = out_data;
            lm[beats]       = out_last;
            beats++;
            have_prev = 1'b0;
         end else begin
            have_prev = out_valid;
            prev_d    = out_data;
            prev_l    = out_last;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (d !== 32'hF9873310 || beats !== 8 || lm !== 8'h80) begin
         n_err++;
         $display("FAIL stall_data: got %h last %b (%0d beats) want f9873310 last 10000000 (8)",
                  d, lm, beats);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_reset_mid_sort();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h89ABCDEF, 8);
      repeat (10) tick();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_sort_busy_before: got %b want 1", busy);
      end
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL rst_sort_state: got rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
      end
      load_beats(32'h813F0937, 8);
      run_sort(cyc);
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'hF9873310 || lm !== 8'h80) begin
         n_err++;
         $display("FAIL rst_sort_fresh: got %h last %b want f9873310 last 10000000", d, lm);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] d;
      logic [7:0]  lm;
      int          beats, cyc;
      load_beats(32'h00001234, 4);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL rst_load_state: got rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
      end
      load_beats(32'h89ABCDEF, 8);
      run_sort(cyc);
      n_cmp++;
      if (cyc !== 28) begin
         n_err++;
         $display("FAIL rst_load_busy_len: got %0d want 28", cyc);
      end
      drain_collect(d, lm, beats);
      n_cmp++;
      if (d !== 32'hFEDCBA98 || beats !== 8) begin
         n_err++;
         $display("FAIL rst_load_fresh: got %h (%0d beats) want fedcba98 (8)", d, beats);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_mixed();
      test_sorted();
      test_descending();
      test_equal();
      test_stall();
      test_reset_mid_sort();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 Parameter N, default 8: number of entries per sort batch, at least 2.
REQ-002 Parameter W, default 4: data width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid entry.
REQ-006 in_data  input  W  unsigned entry to load.
REQ-007 in_ready  output  1  engine accepts an entry this cycle.
REQ-008 out_valid  output  1  out_data holds a valid sorted entry.
REQ-009 out_data  output  W  sorted entry, ascending order.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_last  output  1  current output is entry N-1 of the batch.
REQ-012 busy  output  1  engine is in SORT.

Function
REQ-013 The engine SHALL implement three states: LOAD, SORT and DRAIN.
REQ-014 In LOAD, in_ready SHALL be 1, and each in_valid&in_ready beat SHALL write in_data to mem[wr_idx] and then increment wr_idx.
REQ-015 When the Nth beat is accepted, the engine SHALL enter SORT on the next cycle, with pass=0, j=0 and swap_flag=0.
REQ-016 In SORT, the engine SHALL perform exactly one comparison per cycle, comparing mem[j] against mem[j+1] through one shared comparator instance.
REQ-017 In SORT, if the comparator reports mem[j] greater than mem[j+1] (G=1), the two entries SHALL be exchanged at that clock edge and swap_flag SHALL be set.
REQ-018 In SORT, if the comparator reports L=1 or E=1, the entries SHALL NOT be exchanged, so the sort is stable.
REQ-019 j SHALL step from 0 to N-2-pass; at the end of each pass, j SHALL reset to 0, pass SHALL increment and swap_flag SHALL clear.
REQ-020 The engine SHALL leave SORT for DRAIN after either a pass with swap_flag=0 or the completion of pass N-2, whichever occurs first.
REQ-021 SORT SHALL last at most N(N-1)/2 cycles (28 for N=8) and at least N-1 cycles when the input is already sorted.
REQ-022 In DRAIN, out_valid SHALL be 1, out_data SHALL equal mem[rd_idx], and out_last SHALL equal (rd_idx==N-1).
REQ-023 In DRAIN, each out_valid&out_ready beat SHALL increment rd_idx.
REQ-024 The beat that transfers the out_last entry SHALL return the engine to LOAD on the next cycle, with wr_idx and rd_idx cleared.
REQ-025 While out_ready=0 in DRAIN, out_data and out_last SHALL hold stable.
REQ-026 in_ready SHALL be 0 in SORT and DRAIN, and in_valid SHALL be ignored in those states.
REQ-027 out_valid SHALL be 0 in LOAD and SORT.
REQ-028 busy SHALL be 1 exactly in SORT.
REQ-029 All index counters SHALL be sized to clog2(N) bits, with no wrap beyond N-1.
REQ-030 All comparisons SHALL be unsigned, and no arithmetic SHALL be performed on data.
REQ-031 Outputs SHALL be driven only from registered state and mem, with no combinational path from in_valid or out_ready to any output.

Reset
REQ-032 Asserting rst at any time SHALL force state=LOAD and clear wr_idx, rd_idx, j, pass and swap_flag.
REQ-033 During reset, outputs SHALL read in_ready=0 while rst is high; after release they SHALL read in_ready=1, out_valid=0, out_last=0, busy=0 and out_data=0.
REQ-034 mem SHALL be cleared to 0 on reset, and a partial batch interrupted by reset SHALL be discarded.

Structure
REQ-035 The state encoding (LOAD=2'd0, SORT=2'd1, DRAIN=2'd2) and the defaults of N and W SHALL be defined in a shared package, sort_pkg.
REQ-036 The comparison SHALL be performed by one sub-module, mag_cmp, with W-bit inputs a and b and one-hot G/L/E outputs, instantiated exactly once.
REQ-037 The sub-module SHALL be purely combinational, and the controller SHALL contain no other magnitude comparator.

Verification
REQ-038 Load 7,3,9,0,15,3,1,8 with out_ready=1 -> outputs are 0,1,3,3,7,8,9,15 and out_last is 1 only on 15.
REQ-039 Load 0..7 already ascending -> busy is high for exactly 7 cycles and outputs are 0..7.
REQ-040 Load 15..8 descending -> busy is high for exactly 28 cycles and outputs are 8..15.
REQ-041 Load all 5s -> zero swaps, busy is high for 7 cycles, and eight outputs equal 5.
REQ-042 Toggle out_ready every other cycle in DRAIN -> out_data holds while stalled, no entry is lost or duplicated, and in_ready returns to 1 after the last beat.
REQ-043 Assert rst during SORT (cycle 10) and during LOAD (after 4 beats) -> next cycle state is LOAD with in_ready=1 and out_valid=0, and a fresh batch sorts correctly.
